// File: rtl/vga_if.sv
// Video output bundle of the VGA timing generator: 4-bit RGB plus active-low syncs.
// The generator drives it through the master modport; a display sink uses the slave modport.
interface vga_if;
  logic [3:0] color_r;
  logic [3:0] color_g;
  logic [3:0] color_b;
  logic       hs;
  logic       vs;

  modport master (output color_r, output color_g, output color_b, output hs, output vs);
  modport slave  (input  color_r, input  color_g, input  color_b, input  hs, input  vs);
endinterface

// File: rtl/vga.sv
// VGA timing generator with a test pattern: border, eight colour bars and a 64x64 grey box
// that bounces horizontally one step per frame. Every output is registered one clock after the counters.
module vga #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic  clk,
  input  logic  rst,
  vga_if.master video
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // At least 10 bits so that the bar index x[9:7] always exists.
  localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int VW = ($clog2(V_TOTAL) > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VISIBLE = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_RIGHT   = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VISIBLE = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_BOTTOM  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] BOX_Y0    = VW'(V_ACTIVE / 2 - 32);
  localparam logic [VW-1:0] BOX_Y1    = VW'(V_ACTIVE / 2 + 31);
  localparam logic [HW-1:0] BOX_LIMIT = HW'(H_ACTIVE - 64);
  localparam logic [HW-1:0] BOX_STEP  = HW'(4);
  localparam logic [HW-1:0] BOX_SPAN  = HW'(63);

  typedef enum logic {DIR_RIGHT, DIR_LEFT} dir_t;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [HW-1:0] box_x;
  logic [HW-1:0] box_x_next;
  dir_t          dir;
  dir_t          dir_next;
  logic          h_wrap;
  logic          frame_end;
  logic [11:0]   pixel;

  assign h_wrap    = (h_cnt == H_LAST);
  assign frame_end = h_wrap && (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir   <= DIR_RIGHT;
      box_x <= '0;
    end else begin
      dir   <= dir_next;
      box_x <= box_x_next;
    end
  end

  // Box moves only on the last pixel of a frame; it turns around instead of stepping past a limit.
  always_comb begin
    dir_next   = dir;
    box_x_next = box_x;
    if (frame_end) begin
      case (dir)
        DIR_RIGHT: begin
          if (box_x + BOX_STEP > BOX_LIMIT) begin
            box_x_next = box_x - BOX_STEP;
            dir_next   = DIR_LEFT;
          end else begin
            box_x_next = box_x + BOX_STEP;
          end
        end
        DIR_LEFT: begin
          if (box_x < BOX_STEP) begin
            box_x_next = box_x + BOX_STEP;
            dir_next   = DIR_RIGHT;
          end else begin
            box_x_next = box_x - BOX_STEP;
          end
        end
      endcase
    end
  end

  // Priority: blanking, then border, then box, then bars.
  always_comb begin
    pixel = 12'h000;
    if ((h_cnt >= H_VISIBLE) || (v_cnt >= V_VISIBLE)) begin
      pixel = 12'h000;
    end else if ((h_cnt == '0) || (h_cnt == H_RIGHT) || (v_cnt == '0) || (v_cnt == V_BOTTOM)) begin
      pixel = 12'hFFF;
    end else if ((v_cnt >= BOX_Y0) && (v_cnt <= BOX_Y1) &&
                 (h_cnt >= box_x) && (h_cnt <= box_x + BOX_SPAN)) begin
      pixel = 12'h888;
    end else begin
      case (h_cnt[9:7])
        3'd0: pixel = 12'hFFF;
        3'd1: pixel = 12'hFF0;
        3'd2: pixel = 12'h0FF;
        3'd3: pixel = 12'h0F0;
        3'd4: pixel = 12'hF0F;
        3'd5: pixel = 12'hF00;
        3'd6: pixel = 12'h00F;
        3'd7: pixel = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      video.hs      <= 1'b1;
      video.vs      <= 1'b1;
      video.color_r <= 4'h0;
      video.color_g <= 4'h0;
      video.color_b <= 4'h0;
    end else begin
      video.hs      <= !((h_cnt >= HS_START) && (h_cnt <= HS_END));
      video.vs      <= !((v_cnt >= VS_START) && (v_cnt <= VS_END));
      video.color_r <= pixel[11:8];
      video.color_g <= pixel[7:4];
      video.color_b <= pixel[3:0];
    end
  end

endmodule

// File: tb/tb_vga.sv
// Bench for vga: two instances (full-width lines with a short frame, and a tiny raster for frame-level
// behaviour) checked every clock against an independent pixel/sync model through a scoreboard queue.
module tb_vga;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  vga_if bus_a();
  vga_if bus_b();

  vga #(.V_ACTIVE(64), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_a (
    .clk(clk), .rst(rst_a), .video(bus_a)
  );

  vga #(.H_ACTIVE(80), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(64), .V_FP(2), .V_SYNC(3), .V_BP(3)) dut_b (
    .clk(clk), .rst(rst_b), .video(bus_b)
  );

  typedef struct {
    bit          is_b;
    int          k;
    logic [13:0] exp;
  } sb_t;

  sb_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int ka = 0;
  int kb = 0;

  int   a_first = -1, a_last = -1, a_period = -1, a_width = -1;
  int   b_first = -1, b_last = -1, b_period = -1, b_width = -1;
  logic a_prev_hs = 1'b1;
  logic b_prev_vs = 1'b1;

  // Expected {rgb, hs, vs} after the k-th clock edge since reset release (edge k shows counter index k-1).
  function automatic logic [13:0] model(int k, int ha, int hfp, int hsw, int hbp,
                                        int va, int vfp, int vsw, int vbp);
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    int ht = ha + hfp + hsw + hbp;
    int vt = va + vfp + vsw + vbp;
    int n = k - 1;
    int x = n % ht;
    int line = n / ht;
    int y = line % vt;
    int frame = line / vt;
    int steps = (ha - 64) / 4;
    int t = frame % (2 * steps);
    int bx = (t <= steps) ? 4 * t : 4 * (2 * steps - t);
    logic [11:0] rgb;
    logic h;
    logic v;
    if (x >= ha || y >= va)                           rgb = 12'h000;
    else if (x == 0 || x == ha - 1 || y == 0 || y == va - 1) rgb = 12'hFFF;
    else if (y >= va / 2 - 32 && y <= va / 2 + 31 && x >= bx && x <= bx + 63) rgb = 12'h888;
    else                                              rgb = bars[(x / 128) % 8];
    h = !(x >= ha + hfp && x < ha + hfp + hsw);
    v = !(y >= va + vfp && y < va + vfp + vsw);
    return {rgb, h, v};
  endfunction

  function automatic logic [13:0] model_a(int k);
    return model(k, 1024, 24, 136, 160, 64, 1, 2, 1);
  endfunction

  function automatic logic [13:0] model_b(int k);
    return model(k, 80, 4, 8, 4, 64, 2, 3, 3);
  endfunction

  function automatic logic [13:0] observe(bit is_b);
    if (is_b) return {bus_b.color_r, bus_b.color_g, bus_b.color_b, bus_b.hs, bus_b.vs};
    return {bus_a.color_r, bus_a.color_g, bus_a.color_b, bus_a.hs, bus_a.vs};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: push expectations for the enabled instances, step, then drain the scoreboard.
  task automatic apply_stimulus(input bit chk_a, input bit chk_b);
    if (chk_a) begin
      ka++;
      sb_q.push_back('{is_b: 1'b0, k: ka, exp: model_a(ka)});
    end
    if (chk_b) begin
      kb++;
      sb_q.push_back('{is_b: 1'b1, k: kb, exp: model_b(kb)});
    end
    @(posedge clk);
    @(negedge clk);
    while (sb_q.size() > 0) begin
      sb_t e = sb_q.pop_front();
      check_output($sformatf("%s k=%0d", e.is_b ? "pix_b" : "pix_a", e.k),
                   32'(observe(e.is_b)), 32'(e.exp));
    end
    if (chk_a) begin
      if (a_prev_hs && !bus_a.hs) begin
        if (a_first < 0) a_first = ka;
        else if (a_period < 0) a_period = ka - a_last;
        a_last = ka;
      end
      if (!a_prev_hs && bus_a.hs && a_width < 0) a_width = ka - a_last;
      a_prev_hs = bus_a.hs;
    end
    if (chk_b) begin
      if (b_prev_vs && !bus_b.vs) begin
        if (b_first < 0) b_first = kb;
        else if (b_period < 0) b_period = kb - b_last;
        b_last = kb;
      end
      if (!b_prev_vs && bus_b.vs && b_width < 0) b_width = kb - b_last;
      b_prev_vs = bus_b.vs;
    end
  endtask

  task automatic directed_pixel(input string tag, input bit is_b, input logic [11:0] exp);
    logic [13:0] o;
    o = observe(is_b);
    check_output(tag, 32'(o[13:2]), 32'(exp));
  endtask

  initial begin
    int guard;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    check_output("reset_a", 32'(observe(1'b0)), 32'(14'b00000000000011));
    check_output("reset_b", 32'(observe(1'b1)), 32'(14'b00000000000011));

    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 35000; i++) begin
      apply_stimulus(1'b1, 1'b1);
      if (ka == 1344 + 11)   directed_pixel("a_y1_x10_box", 1'b0, 12'h888);
      if (ka == 1344 + 65)   directed_pixel("a_y1_x64_bar0", 1'b0, 12'hFFF);
      if (ka == 1344 + 201)  directed_pixel("a_y1_x200_bar1", 1'b0, 12'hFF0);
      if (ka == 1344 + 401)  directed_pixel("a_y1_x400_bar3", 1'b0, 12'h0F0);
      if (ka == 1344 + 601)  directed_pixel("a_y1_x600_bar4", 1'b0, 12'hF0F);
      if (ka == 1344 + 901)  directed_pixel("a_y1_x900_bar7", 1'b0, 12'h000);
      if (ka == 1344 + 1024) directed_pixel("a_y1_x1023_border", 1'b0, 12'hFFF);
      if (ka == 1344 + 1101) directed_pixel("a_y1_x1100_blank", 1'b0, 12'h000);
      if (kb == 7012)  directed_pixel("b_f1_x3", 1'b1, 12'hFFF);
      if (kb == 7013)  directed_pixel("b_f1_x4_box", 1'b1, 12'h888);
      if (kb == 27760) directed_pixel("b_f4_x15", 1'b1, 12'hFFF);
      if (kb == 27761) directed_pixel("b_f4_x16_box", 1'b1, 12'h888);
      if (kb == 34668) directed_pixel("b_f5_x11", 1'b1, 12'hFFF);
      if (kb == 34669) directed_pixel("b_f5_x12_box", 1'b1, 12'h888);
      if (kb == 34733) directed_pixel("b_f5_x76_after_box", 1'b1, 12'hFFF);
    end
    check_output("a_hs_first_fall", 32'(a_first), 32'd1049);
    check_output("a_hs_period", 32'(a_period), 32'd1344);
    check_output("a_hs_width", 32'(a_width), 32'd136);
    check_output("b_vs_first_fall", 32'(b_first), 32'd6337);
    check_output("b_vs_period", 32'(b_period), 32'd6912);
    check_output("b_vs_width", 32'(b_width), 32'd288);

    guard = 0;
    while (bus_a.hs !== 1'b0 && guard < 2000) begin
      apply_stimulus(1'b1, 1'b1);
      guard++;
    end
    repeat (5) apply_stimulus(1'b1, 1'b1);
    check_output("a_hs_low_before_reset", 32'(bus_a.hs), 32'd0);

    #2 rst_a = 1'b0;
    #1 check_output("a_async_reset", 32'(observe(1'b0)), 32'(14'b00000000000011));
    repeat (2) begin
      apply_stimulus(1'b0, 1'b1);
      check_output("a_held_reset", 32'(observe(1'b0)), 32'(14'b00000000000011));
    end

    rst_a = 1'b1;
    ka = 0;
    a_first = -1; a_last = -1; a_period = -1; a_width = -1;
    a_prev_hs = 1'b1;
    for (int i = 0; i < 2 * 1344 + 100; i++) apply_stimulus(1'b1, 1'b1);
    check_output("a_rerun_hs_first_fall", 32'(a_first), 32'd1049);
    check_output("a_rerun_hs_period", 32'(a_period), 32'd1344);
    check_output("a_rerun_hs_width", 32'(a_width), 32'd136);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga.md
VGA -- requirements
Module: vga

Interface
REQ-001 Parameter H_ACTIVE, 1024, visible pixels per line.
REQ-002 Parameter H_FP, 24, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 136, horizontal sync width in clocks.
REQ-004 Parameter H_BP, 160, horizontal back porch in clocks; line total = 1344.
REQ-005 Parameter V_ACTIVE, 768, visible lines per frame.
REQ-006 Parameter V_FP, 3, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 6, vertical sync width in lines.
REQ-008 Parameter V_BP, 29, vertical back porch in lines; frame total = 806.
REQ-009 clk  input  1  65 MHz pixel clock; all logic on its rising edge.
REQ-010 rst  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-011 color_r  output  4  red intensity.
REQ-012 color_g  output  4  green intensity.
REQ-013 color_b  output  4  blue intensity.
REQ-014 hs  output  1  horizontal sync, active-low.
REQ-015 vs  output  1  vertical sync, active-low.

Function
REQ-016 The horizontal counter h_cnt SHALL count 0..1343 and wrap to 0.
REQ-017 The vertical counter v_cnt SHALL increment only when h_cnt wraps, count 0..805, and wrap to 0.
REQ-018 hs SHALL be 0 for exactly one clock after each cycle in which h_cnt is in 1048..1183, and 1 otherwise.
REQ-019 vs SHALL be 0 for exactly one clock after each cycle in which v_cnt is in 771..776, and 1 otherwise.
REQ-020 All outputs SHALL be registered with exactly one clock of latency from the counter values (x = h_cnt, y = v_cnt).
REQ-021 When x>=1024 or y>=768 (blanking), color outputs SHALL be 0x000.
REQ-022 Border: x==0, x==1023, y==0 or y==767 SHALL output RGB 0xFFF.
REQ-023 Box: 64x64 with y in 352..415 and x in box_x..box_x+63 SHALL output 0x888 and takes priority over the bars.
REQ-024 Bars: otherwise, bar index x[9:7] SHALL select the colour.
REQ-025 Bar colours: 0 FFF, 1 FF0, 2 0FF, 3 0F0, 4 F0F, 5 F00, 6 00F, 7 000.
REQ-026 box_x SHALL update once per frame, in the cycle where h_cnt==1343 and v_cnt==805.
REQ-027 box_x update rule: moving right it adds 4, moving left it subtracts 4.
REQ-028 Direction SHALL reverse when box_x reaches 960 (right limit) or 0 (left limit), so box_x never leaves 0..960.

Reset
REQ-029 While rst=0, h_cnt, v_cnt and box_x SHALL be 0, direction SHALL be right, hs=1, vs=1 and all colours 0.
REQ-030 Reset SHALL take effect asynchronously.
REQ-031 On the first rising edge after rst rises, counting SHALL start from h_cnt=0, v_cnt=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately, with no partial sync pulse completed.

Verification
REQ-033 Release reset, count clocks between hs falling edges -> 1344; hs low width = 136 clocks; first hs fall is 1049 clocks after the first counting edge.
REQ-034 Measure vs -> period 806*1344 = 1083264 clocks; low width 6*1344 = 8064 clocks.
REQ-035 Frame 0, line 100 -> pixels 1..127 = FFF, 128..255 = FF0, 896..1022 = 000, pixel 1023 = FFF, pixels 1024..1343 = 000.
REQ-036 Frame 0, line 360 -> pixels 1..63 = 888, 64..127 = FFF; frame 1 -> box at x 4..67; after 240 frames box_x=960, then 956.
REQ-037 Assert rst=0 mid-line with hs low -> hs=1 and colours 0 without waiting for a clock; after release the timing of REQ-033 repeats exactly.
